// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges per-stage stall requests into hold/bubble controls
// and sequences EX redirects into the PC generator, parking them while IF is busy.
module pipe_ctrl #(
   parameter int PC_W     = 64,
   parameter int WAIT_MAX = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_stall_req,
   input  logic            id_stall_req,
   input  logic            ex_stall_req,
   input  logic            mem_stall_req,
   input  logic            ex_redirect_ena,
   input  logic [PC_W-1:0] ex_redirect_pc,
   output logic [4:0]      stall_o,
   output logic [4:0]      flush_o,
   output logic            pc_redirect_ena,
   output logic [PC_W-1:0] pc_redirect_pc,
   output logic            ex_hold_o,
   output logic            redirect_pend_o,
   output logic            err_o
);

   typedef enum logic {
      IDLE,
      WAIT_IF
   } state_e;

   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pendPc_q, pendPc_d;
   logic [7:0]      waitCnt_q, waitCnt_d;
   logic            err_q, err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pendPc_q  <= '0;
         waitCnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pendPc_q  <= pendPc_d;
         waitCnt_q <= waitCnt_d;
         err_q     <= err_d;
      end
   end

   // A taken redirect flushes IF/ID and ID/EX, which makes any ID or IF stall moot.
   always_comb begin
      state_d         = state_q;
      pendPc_d        = pendPc_q;
      waitCnt_d       = waitCnt_q;
      err_d           = err_q;
      stall_o         = 5'b00000;
      flush_o         = 5'b00000;
      pc_redirect_ena = 1'b0;
      pc_redirect_pc  = '0;

      case (state_q)
         IDLE: begin
            if (mem_stall_req) begin
               stall_o = 5'b11111;
            end else if (ex_stall_req) begin
               stall_o = 5'b01111;
               flush_o = 5'b10000;
            end else if (ex_redirect_ena) begin
               flush_o = 5'b00110;
               if (!if_stall_req) begin
                  pc_redirect_ena = 1'b1;
                  pc_redirect_pc  = ex_redirect_pc;
               end else begin
                  stall_o   = 5'b00001;
                  pendPc_d  = ex_redirect_pc;
                  waitCnt_d = '0;
                  state_d   = WAIT_IF;
               end
            end else if (id_stall_req) begin
               stall_o = 5'b00111;
               flush_o = 5'b01000;
            end else if (if_stall_req) begin
               stall_o = 5'b00011;
               flush_o = 5'b00100;
            end
         end

         WAIT_IF: begin
            if (waitCnt_q != 8'hFF) begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
            if (mem_stall_req) begin
               stall_o = 5'b11111;
            end else begin
               stall_o = 5'b00001;
               flush_o = 5'b00110;
            end
            // The parked redirect may issue even under a MEM stall.
            if (!if_stall_req) begin
               pc_redirect_ena = 1'b1;
               pc_redirect_pc  = pendPc_q;
               state_d         = IDLE;
            end else begin
               if (waitCnt_q == WAIT_LIMIT) begin
                  err_d = 1'b1;
               end
               if (ex_redirect_ena) begin
                  pendPc_d = ex_redirect_pc;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ex_hold_o       = stall_o[3];
   assign redirect_pend_o = (state_q == WAIT_IF);
   assign err_o           = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expected outputs are queued when
// stimulus is driven and popped for comparison at the following falling edge.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        ifS, idS, exS, memS, redir;
   logic [63:0] rpc;
   logic [4:0]  stall_o, flush_o;
   logic        pc_redirect_ena;
   logic [63:0] pc_redirect_pc;
   logic        ex_hold_o, redirect_pend_o, err_o;

   int          checks;
   int          errors;
   logic [77:0] expQ[$];
   logic [77:0] got, exp;

   localparam logic [63:0] PC_A = 64'h0000_0000_8000_0100;
   localparam logic [63:0] PC_B = 64'h0000_0000_8000_2000;
   localparam logic [63:0] PC_C = 64'hFFFF_0000_1234_5678;

   pipe_ctrl #(.PC_W(64), .WAIT_MAX(255)) dut (
      .clk             (clk),
      .rst             (rst),
      .if_stall_req    (ifS),
      .id_stall_req    (idS),
      .ex_stall_req    (exS),
      .mem_stall_req   (memS),
      .ex_redirect_ena (redir),
      .ex_redirect_pc  (rpc),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .pc_redirect_ena (pc_redirect_ena),
      .pc_redirect_pc  (pc_redirect_pc),
      .ex_hold_o       (ex_hold_o),
      .redirect_pend_o (redirect_pend_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [77:0] mk(input logic [4:0] s, input logic [4:0] f, input logic e,
                                      input logic [63:0] p, input logic pd, input logic er);
      return {s, f, e, p, s[3], pd, er};
   endfunction

   function automatic logic [77:0] obs();
      return {stall_o, flush_o, pc_redirect_ena, pc_redirect_pc, ex_hold_o, redirect_pend_o, err_o};
   endfunction

   task automatic setIn(input logic i, input logic d, input logic x, input logic m,
                        input logic r, input logic [63:0] p);
      ifS = i; idS = d; exS = x; memS = m; redir = r; rpc = p;
   endtask

   task automatic test_reset();
      setIn(0, 0, 0, 0, 0, 64'h0);
      expQ.push_back(mk(5'b0, 5'b0, 0, 64'h0, 0, 0));
      @(negedge clk);
      got = obs(); exp = expQ.pop_front(); checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL reset got=%h exp=%h", got, exp);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         setIn(0, 0, 0, 0, 0, 64'h0);
         expQ.push_back(mk(5'b0, 5'b0, 0, 64'h0, 0, 0));
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL idle cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect();
      for (int c = 0; c < 2; c++) begin
         if (c == 0) begin
            setIn(0, 0, 0, 0, 1, PC_A);
            expQ.push_back(mk(5'b00000, 5'b00110, 1, PC_A, 0, 0));
         end else begin
            setIn(0, 0, 0, 0, 0, PC_B);
            expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 0));
         end
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL redirect cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_priority();
      logic [3:0] req [6];
      logic [4:0] es  [6];
      logic [4:0] ef  [6];
      // req = {mem, ex, id, if}
      req[0] = 4'b1000; es[0] = 5'b11111; ef[0] = 5'b00000;
      req[1] = 4'b0100; es[1] = 5'b01111; ef[1] = 5'b10000;
      req[2] = 4'b0010; es[2] = 5'b00111; ef[2] = 5'b01000;
      req[3] = 4'b0001; es[3] = 5'b00011; ef[3] = 5'b00100;
      req[4] = 4'b0011; es[4] = 5'b00111; ef[4] = 5'b01000;
      req[5] = 4'b1111; es[5] = 5'b11111; ef[5] = 5'b00000;
      for (int c = 0; c < 6; c++) begin
         setIn(req[c][0], req[c][1], req[c][2], req[c][3], 0, PC_C);
         expQ.push_back(mk(es[c], ef[c], 0, 64'h0, 0, 0));
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL priority cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wait_if();
      for (int c = 0; c < 5; c++) begin
         case (c)
            0: begin
               setIn(1, 0, 0, 0, 1, PC_A);
               expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 0, 0));
            end
            1, 2: begin
               setIn(1, 0, 0, 0, 0, 64'h0);
               expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 1, 0));
            end
            3: begin
               setIn(0, 0, 0, 0, 0, 64'h0);
               expQ.push_back(mk(5'b00001, 5'b00110, 1, PC_A, 1, 0));
            end
            default: begin
               setIn(0, 0, 0, 0, 0, 64'h0);
               expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 0));
            end
         endcase
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL wait_if cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_hold();
      for (int c = 0; c < 5; c++) begin
         if (c < 2) begin
            setIn(0, 1, 0, 1, 1, PC_B);
            expQ.push_back(mk(5'b11111, 5'b00000, 0, 64'h0, 0, 0));
         end else if (c == 2) begin
            setIn(0, 1, 1, 0, 1, PC_B);
            expQ.push_back(mk(5'b01111, 5'b10000, 0, 64'h0, 0, 0));
         end else if (c == 3) begin
            setIn(0, 1, 0, 0, 1, PC_B);
            expQ.push_back(mk(5'b00000, 5'b00110, 1, PC_B, 0, 0));
         end else begin
            setIn(0, 0, 0, 0, 0, 64'h0);
            expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 0));
         end
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL mem_hold cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 7; c++) begin
         case (c)
            0: begin
               setIn(1, 0, 0, 0, 1, PC_A);
               expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 0, 0));
            end
            1: begin
               setIn(1, 0, 0, 1, 0, 64'h0);
               expQ.push_back(mk(5'b11111, 5'b00000, 0, 64'h0, 1, 0));
            end
            2: begin
               setIn(1, 0, 0, 0, 1, PC_B);
               expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 1, 0));
            end
            3: begin
               setIn(0, 0, 0, 1, 0, 64'h0);
               expQ.push_back(mk(5'b11111, 5'b00000, 1, PC_B, 1, 0));
            end
            4: begin
               setIn(0, 0, 0, 0, 0, 64'h0);
               expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 0));
            end
            5: begin
               setIn(0, 0, 0, 0, 1, PC_A);
               expQ.push_back(mk(5'b00000, 5'b00110, 1, PC_A, 0, 0));
            end
            default: begin
               setIn(0, 0, 0, 0, 1, PC_C);
               expQ.push_back(mk(5'b00000, 5'b00110, 1, PC_C, 0, 0));
            end
         endcase
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL back_to_back cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      // cycle 0 enters WAIT_IF, cycles 1..257 hold IF busy, 258 releases, 259 idles
      for (int c = 0; c < 260; c++) begin
         if (c == 0) begin
            setIn(1, 0, 0, 0, 1, PC_C);
            expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 0, 0));
         end else if (c <= 257) begin
            setIn(1, 0, 0, 0, 0, 64'h0);
            expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 1, (c == 257)));
         end else if (c == 258) begin
            setIn(0, 0, 0, 0, 0, 64'h0);
            expQ.push_back(mk(5'b00001, 5'b00110, 1, PC_C, 1, 1));
         end else begin
            setIn(0, 0, 0, 0, 0, 64'h0);
            expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 1));
         end
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL timeout cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_wait();
      for (int c = 0; c < 6; c++) begin
         if (c == 0) begin
            setIn(1, 0, 0, 0, 1, PC_B);
            expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 0, 1));
         end else if (c == 1) begin
            setIn(1, 0, 0, 0, 0, 64'h0);
            expQ.push_back(mk(5'b00001, 5'b00110, 0, 64'h0, 1, 1));
         end else if (c == 2) begin
            setIn(0, 0, 0, 0, 0, 64'h0);
            rst = 1'b0;
            expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 0));
         end else begin
            if (c == 3) rst = 1'b1;
            setIn(0, 0, 0, 0, 0, 64'h0);
            expQ.push_back(mk(5'b00000, 5'b00000, 0, 64'h0, 0, 0));
         end
         @(negedge clk);
         got = obs(); exp = expQ.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_wait cyc%0d got=%h exp=%h", c, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      clk    = 1'b0;
      rst    = 1'b0;
      checks = 0;
      errors = 0;
      setIn(0, 0, 0, 0, 0, 64'h0);
      #2;
      test_reset();
      test_idle();
      test_redirect();
      test_priority();
      test_wait_if();
      test_mem_hold();
      test_back_to_back();
      test_timeout();
      test_reset_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
